// File: rtl/z_result_stage_pkg.sv
// Shared definitions for the Z result stage.
// - WIDTH_DEF : default width of one bus beat and of each Z half
// - entry_width(): packed FIFO entry width for the {wide, hi, lo} record
// - S_LO / S_HI : serialiser state encodings (low beat / high beat)
package z_result_stage_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  // Entry layout, MSB first: {wide, hi[WIDTH-1:0], lo[WIDTH-1:0]}
  function automatic int unsigned entry_width(input int unsigned w);
    return 2 * w + 1;
  endfunction

  localparam int unsigned ENTRY_W_DEF = 2 * WIDTH_DEF + 1;

  localparam logic S_LO = 1'b0;
  localparam logic S_HI = 1'b1;

endpackage

// File: rtl/z_result_stage_result_fifo.sv
// Generic register FIFO, DEPTH entries of EW bits.
// Ports:
//   clk, clr_n   : clock, asynchronous active-low reset
//   push, wdata  : write wdata at the tail (caller ensures !full)
//   pop          : drop the head entry (caller ensures !empty)
//   rdata        : current head entry
//   full, empty  : occupancy flags, derived from the entry count
module z_result_stage_result_fifo #(
  parameter int unsigned EW    = 65,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          push,
  input  logic [EW-1:0] wdata,
  input  logic          pop,
  output logic [EW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/z_result_stage.sv
// Z result stage: captures ALU results into the Z register pair and
// serialises buffered results onto the internal bus (lo beat, then hi beat
// for wide results).
// Ports:
//   clk, clr_n                 : clock, asynchronous active-low reset
//   alu_valid/alu_ready        : ALU result handshake
//   alu_wide, alu_lo, alu_hi   : result payload (hi ignored when narrow)
//   bus_valid/bus_ready        : bus beat handshake
//   bus_data, bus_hi           : current beat and its half indicator
//   zlo, zhi                   : architectural Zlow / Zhigh
//   busy                       : results pending
module z_result_stage
  import z_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic             alu_wide,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_hi,
  output logic [WIDTH-1:0] zlo,
  output logic [WIDTH-1:0] zhi,
  output logic             busy
);

  localparam int unsigned EW = entry_width(WIDTH);

  logic             push, pop, full, empty, beat_done;
  logic [EW-1:0]    head;
  logic             head_wide;
  logic [WIDTH-1:0] head_hi, head_lo;
  logic             state_q, state_d;
  logic [WIDTH-1:0] zlo_q, zhi_q;

  z_result_stage_result_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push),
    .wdata ({alu_wide, alu_hi, alu_lo}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign head_wide = head[2*WIDTH];
  assign head_hi   = head[2*WIDTH-1:WIDTH];
  assign head_lo   = head[WIDTH-1:0];

  // Ready comes only from registered occupancy: a full FIFO never accepts,
  // even if the head is popped in the same cycle.
  assign alu_ready = !full;
  assign push      = alu_valid && alu_ready;

  assign bus_valid = !empty;
  assign beat_done = bus_valid && bus_ready;
  // A wide entry leaves the FIFO only after its high beat.
  assign pop       = beat_done && ((state_q == S_HI) || !head_wide);

  always_comb begin
    state_d = state_q;
    if (beat_done) state_d = ((state_q == S_LO) && head_wide) ? S_HI : S_LO;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_LO;
      zlo_q   <= '0;
      zhi_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        zlo_q <= alu_lo;
        zhi_q <= alu_wide ? alu_hi : '0;  // narrow ops clear Zhigh
      end
    end
  end

  assign bus_data = (state_q == S_HI) ? head_hi : head_lo;
  assign bus_hi   = (state_q == S_HI);
  assign zlo      = zlo_q;
  assign zhi      = zhi_q;
  assign busy     = !empty;

endmodule
